// File: rtl/decode_pkg.sv
// Shared types for the registered RV32I decode queue stage: opcode constants,
// ALU / branch / immediate-format enums, the queued control bundle and the
// immediate generator.
// Build option: DECODE_M_EXT_EN widens the ALU code to 5 bits and adds the
// multiply/divide operations.
package decode_pkg;

`ifdef DECODE_M_EXT_EN
   localparam int ALU_W = 5;
`else
   localparam int ALU_W = 4;
`endif

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [ALU_W-1:0] {
      ALU_ADD    = ALU_W'(0),
      ALU_SUB    = ALU_W'(1),
      ALU_SLL    = ALU_W'(2),
      ALU_SLT    = ALU_W'(3),
      ALU_SLTU   = ALU_W'(4),
      ALU_XOR    = ALU_W'(5),
      ALU_SRL    = ALU_W'(6),
      ALU_SRA    = ALU_W'(7),
      ALU_OR     = ALU_W'(8),
      ALU_AND    = ALU_W'(9)
`ifdef DECODE_M_EXT_EN
      ,
      ALU_MUL    = ALU_W'(10),
      ALU_MULH   = ALU_W'(11),
      ALU_MULHSU = ALU_W'(12),
      ALU_MULHU  = ALU_W'(13),
      ALU_DIV    = ALU_W'(14),
      ALU_DIVU   = ALU_W'(15),
      ALU_REM    = ALU_W'(16),
      ALU_REMU   = ALU_W'(17)
`endif
   } alu_e;

   // Branch codes equal the branch funct3; BR_NONE reuses the reserved
   // funct3 010 so non-branch bundles never look like a BEQ.
   typedef enum logic [2:0] {
      BR_EQ   = 3'b000,
      BR_NE   = 3'b001,
      BR_NONE = 3'b010,
      BR_RSV  = 3'b011,
      BR_LT   = 3'b100,
      BR_GE   = 3'b101,
      BR_LTU  = 3'b110,
      BR_GEU  = 3'b111
   } br_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   // Immediate is kept at 32 bits in the queue; the top sign-extends to XLEN.
   typedef struct packed {
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      alu_e        alu_sel;
      br_e         br_sel;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        pc_change;
      logic        illegal;
   } bundle_t;

   function automatic logic [31:0] gen_imm(input logic [31:0] instr,
                                           input imm_fmt_e    fmt);
      case (fmt)
         IMM_I:   return {{20{instr[31]}}, instr[31:20]};
         IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
         IMM_U:   return {instr[31:12], 12'b0};
         IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
         default: return '0;
      endcase
   endfunction

   // Base integer ALU op; alt selects SUB/SRA.
   function automatic alu_e alu_from_funct3(input logic [2:0] funct3,
                                            input logic       alt);
      case (funct3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

`ifdef DECODE_M_EXT_EN
   function automatic alu_e alu_from_mext(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return ALU_MUL;
         3'b001:  return ALU_MULH;
         3'b010:  return ALU_MULHSU;
         3'b011:  return ALU_MULHU;
         3'b100:  return ALU_DIV;
         3'b101:  return ALU_DIVU;
         3'b110:  return ALU_REM;
         default: return ALU_REMU;
      endcase
   endfunction
`endif

endpackage

// File: rtl/decode_logic.sv
// Purely combinational RV32I decoder: instruction word -> control bundle.
// Build option: DECODE_M_EXT_EN accepts funct7 0000001 on OP as mul/div;
// without it that encoding is flagged illegal.
module decode_logic
   import decode_pkg::*;
(
   input  logic [31:0] i_instr,
   output bundle_t     o_bundle
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic [4:0] w_rd;

   alu_e       w_alu;
   br_e        w_br;
   imm_fmt_e   w_fmt;
   logic       w_legal;
   logic       w_writes_rd;
   logic       w_load;
   logic       w_store;
   logic       w_redirect;

   assign w_opcode = i_instr[6:0];
   assign w_rd     = i_instr[11:7];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];

   // Classify the opcode and derive legality, ALU/branch codes and imm format.
   // NOTE: every signal driven here gets a default at the top, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      w_alu       = ALU_ADD;
      w_br        = BR_NONE;
      w_fmt       = IMM_NONE;
      w_legal     = 1'b0;
      w_writes_rd = 1'b0;
      w_load      = 1'b0;
      w_store     = 1'b0;
      w_redirect  = 1'b0;
      case (w_opcode)
         OPC_OP: begin
            w_writes_rd = 1'b1;
            if (w_funct7 == F7_BASE) begin
               w_legal = 1'b1;
               w_alu   = alu_from_funct3(w_funct3, 1'b0);
            end else if (w_funct7 == F7_ALT &&
                         (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
               w_legal = 1'b1;
               w_alu   = alu_from_funct3(w_funct3, 1'b1);
            end
`ifdef DECODE_M_EXT_EN
            else if (w_funct7 == F7_MULDIV) begin
               w_legal = 1'b1;
               w_alu   = alu_from_mext(w_funct3);
            end
`endif
         end
         OPC_OP_IMM: begin
            w_writes_rd = 1'b1;
            w_fmt       = IMM_I;
            case (w_funct3)
               3'b001:  w_legal = (w_funct7 == F7_BASE);
               3'b101:  w_legal = (w_funct7 == F7_BASE) || (w_funct7 == F7_ALT);
               default: w_legal = 1'b1;
            endcase
            // The funct7 alternate bit only means SRA for immediate shifts.
            w_alu = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
         end
         OPC_LOAD: begin
            w_legal     = w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            w_writes_rd = 1'b1;
            w_load      = 1'b1;
            w_fmt       = IMM_I;
         end
         OPC_STORE: begin
            w_legal = w_funct3 inside {3'b000, 3'b001, 3'b010};
            w_store = 1'b1;
            w_fmt   = IMM_S;
         end
         OPC_BRANCH: begin
            w_legal    = !(w_funct3 inside {3'b010, 3'b011});
            w_br       = br_e'(w_funct3);
            w_redirect = 1'b1;
            w_fmt      = IMM_B;
         end
         OPC_JAL: begin
            w_legal     = 1'b1;
            w_writes_rd = 1'b1;
            w_redirect  = 1'b1;
            w_fmt       = IMM_J;
         end
         OPC_JALR: begin
            w_legal     = (w_funct3 == 3'b000);
            w_writes_rd = 1'b1;
            w_redirect  = 1'b1;
            w_fmt       = IMM_I;
         end
         OPC_LUI, OPC_AUIPC: begin
            w_legal     = 1'b1;
            w_writes_rd = 1'b1;
            w_fmt       = IMM_U;
         end
         default: ;
      endcase
   end

   // Pack the bundle; an illegal instruction keeps its fields but has every
   // side effect suppressed.
   always_comb begin
      o_bundle.opcode    = w_opcode;
      o_bundle.funct3    = w_funct3;
      o_bundle.alu_sel   = w_alu;
      o_bundle.br_sel    = w_br;
      o_bundle.imm       = gen_imm(i_instr, w_fmt);
      o_bundle.rs1       = i_instr[19:15];
      o_bundle.rs2       = i_instr[24:20];
      o_bundle.rd        = w_rd;
      o_bundle.reg_we    = w_legal && w_writes_rd && (w_rd != 5'd0);
      o_bundle.mem_rd    = w_legal && w_load;
      o_bundle.mem_wr    = w_legal && w_store;
      o_bundle.pc_change = w_legal && w_redirect;
      o_bundle.illegal   = !w_legal;
   end

endmodule

// File: rtl/decode_queue_stage.sv
// Registered decode stage between fetch and execute: decodes each accepted
// instruction and buffers the bundle in a DEPTH-entry FIFO with independent
// valid/ready handshakes on both sides and a flush for taken redirects.
// Build option: DECODE_M_EXT_EN (mul/div decode, 5-bit out_alu_sel).
module decode_queue_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [XLEN-1:0]        in_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [6:0]             out_opcode,
   output logic [2:0]             out_funct3,
   output logic [ALU_W-1:0]       out_alu_sel,
   output logic [2:0]             out_br_sel,
   output logic [XLEN-1:0]        out_imm,
   output logic [4:0]             out_rs1,
   output logic [4:0]             out_rs2,
   output logic [4:0]             out_rd,
   output logic                   out_reg_we,
   output logic                   out_mem_rd,
   output logic                   out_mem_wr,
   output logic                   out_pc_change,
   output logic                   out_illegal,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int              PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W:0]  DEPTH_CNT = DEPTH[PTR_W:0];

   bundle_t          w_decoded;
   bundle_t          w_head;
   logic             w_push;
   logic             w_pop;

   bundle_t          r_bundle [DEPTH];
   logic [XLEN-1:0]  r_pc     [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   decode_logic u_decode (
      .i_instr  (in_instr),
      .o_bundle (w_decoded)
   );

   // Ready depends only on stored occupancy, never on out_ready.
   assign in_ready  = !rst && (r_count < DEPTH_CNT) && !flush;
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign occupancy = r_count;

   // Pointer and occupancy bookkeeping; flush outranks push and pop.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: ;
         endcase
      end
   end

   // Write the decoded bundle at the tail.
   // NOTE: the storage array is deliberately not reset; an entry is only ever
   // read after it has been written, and the outputs are gated while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_bundle[r_wr_ptr] <= w_decoded;
         r_pc[r_wr_ptr]     <= in_pc;
      end
   end

   assign w_head = r_bundle[r_rd_ptr];

   // Present the head bundle, or all zeros while the queue is empty.
   always_comb begin
      out_pc        = '0;
      out_opcode    = '0;
      out_funct3    = '0;
      out_alu_sel   = '0;
      out_br_sel    = '0;
      out_imm       = '0;
      out_rs1       = '0;
      out_rs2       = '0;
      out_rd        = '0;
      out_reg_we    = 1'b0;
      out_mem_rd    = 1'b0;
      out_mem_wr    = 1'b0;
      out_pc_change = 1'b0;
      out_illegal   = 1'b0;
      if (out_valid) begin
         out_pc        = r_pc[r_rd_ptr];
         out_opcode    = w_head.opcode;
         out_funct3    = w_head.funct3;
         out_alu_sel   = w_head.alu_sel;
         out_br_sel    = w_head.br_sel;
         out_imm       = XLEN'($signed(w_head.imm));
         out_rs1       = w_head.rs1;
         out_rs2       = w_head.rs2;
         out_rd        = w_head.rd;
         out_reg_we    = w_head.reg_we;
         out_mem_rd    = w_head.mem_rd;
         out_mem_wr    = w_head.mem_wr;
         out_pc_change = w_head.pc_change;
         out_illegal   = w_head.illegal;
      end
   end

endmodule
